// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply / restoring-divide unit that owns the HI/LO pair.
// Signed operations run on magnitudes and apply the recorded signs at the commit step.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] hiLoWriteValue,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divZero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_raw_a;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero_out;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_CALC;
                else       w_next_state = ST_IDLE;
            end
            ST_CALC: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) w_next_state = ST_FIX;
                else                            w_next_state = ST_CALC;
            end
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Operand magnitudes and one shift-add / restoring-divide iteration
    always_comb begin
        w_signed    = ~op[0];
        w_a_neg     = w_signed & rsData[WIDTH-1];
        w_b_neg     = w_signed & rtData[WIDTH-1];
        w_a_mag     = w_a_neg ? (~rsData + {{(WIDTH-1){1'b0}}, 1'b1}) : rsData;
        w_b_mag     = w_b_neg ? (~rtData + {{(WIDTH-1){1'b0}}, 1'b1}) : rtData;
        w_mul_sum   = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_opnd : {WIDTH{1'b0}})};
        w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        if (r_is_div) begin
            if (!w_div_diff[WIDTH]) begin
                w_step_hi = w_div_diff[WIDTH-1:0];
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = w_div_shift[WIDTH-1:0];
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override for the commit step
    always_comb begin
        w_prod     = {r_acc_hi, r_acc_lo};
        w_prod_fix = r_neg_q ? (~w_prod + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_prod;
        if (r_is_div && r_div_zero) begin
            w_fix_hi = r_raw_a;
            w_fix_lo = {WIDTH{1'b1}};
        end else if (r_is_div) begin
            w_fix_hi = r_neg_r ? (~r_acc_hi + {{(WIDTH-1){1'b0}}, 1'b1}) : r_acc_hi;
            w_fix_lo = r_neg_q ? (~r_acc_lo + {{(WIDTH-1){1'b0}}, 1'b1}) : r_acc_lo;
        end else begin
            w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    // Datapath, HI/LO and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt          <= {CNT_W{1'b0}};
            r_acc_hi       <= {WIDTH{1'b0}};
            r_acc_lo       <= {WIDTH{1'b0}};
            r_opnd         <= {WIDTH{1'b0}};
            r_raw_a        <= {WIDTH{1'b0}};
            r_is_div       <= 1'b0;
            r_neg_q        <= 1'b0;
            r_neg_r        <= 1'b0;
            r_div_zero     <= 1'b0;
            r_hi           <= {WIDTH{1'b0}};
            r_lo           <= {WIDTH{1'b0}};
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_div_zero_out <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_div_zero_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // Multiply: multiplicand in r_opnd, multiplier shifts out of r_acc_lo.
                        // Divide: divisor in r_opnd, dividend shifts out of r_acc_lo.
                        r_is_div   <= op[1];
                        r_opnd     <= op[1] ? w_b_mag : w_a_mag;
                        r_acc_lo   <= op[1] ? w_a_mag : w_b_mag;
                        r_acc_hi   <= {WIDTH{1'b0}};
                        r_raw_a    <= rsData;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= op[1] & (rtData == {WIDTH{1'b0}});
                        r_cnt      <= {CNT_W{1'b0}};
                        r_busy     <= 1'b1;
                    end else begin
                        if (mthi) r_hi <= hiLoWriteValue;
                        else      r_hi <= r_hi;
                        if (mtlo) r_lo <= hiLoWriteValue;
                        else      r_lo <= r_lo;
                    end
                end
                ST_CALC: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                ST_FIX: begin
                    r_hi           <= w_fix_hi;
                    r_lo           <= w_fix_lo;
                    r_busy         <= 1'b0;
                    r_done         <= 1'b1;
                    r_div_zero_out <= r_is_div & r_div_zero;
                    r_cnt          <= {CNT_W{1'b0}};
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign busy    = r_busy;
    assign done    = r_done;
    assign divZero = r_div_zero_out;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit; expected HI/LO come from
// plain 64-bit arithmetic on the operands.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hiLoWriteValue;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        divZero;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rsData(rsData), .rtData(rtData), .mthi(mthi), .mtlo(mtlo),
        .hiLoWriteValue(hiLoWriteValue), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .divZero(divZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Architectural result {HI,LO} of one operation
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'h0;
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit with_move);
        logic [63:0] e;
        int          n;
        e = ref_op(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; rsData = a; rtData = b;
        if (with_move) begin
            mthi = 1'b1; mtlo = 1'b1; hiLoWriteValue = $urandom;
        end
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'($urandom); rsData = $urandom; rtData = $urandom;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            chk("hold_hi", hi, m_hi);
            chk("hold_lo", lo, m_lo);
            chk_b("done_low", done, 1'b0);
            if (n == 9) begin
                start = 1'b1; op = 2'b11; mthi = 1'b1; mtlo = 1'b1; hiLoWriteValue = $urandom;
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("busy_cycles", 32'(n), 32'd33);
        m_hi = e[63:32];
        m_lo = e[31:0];
        chk("res_hi", hi, m_hi);
        chk("res_lo", lo, m_lo);
        chk_b("done_pulse", done, 1'b1);
        chk_b("divzero", divZero, (o[1] && b == 32'h0));
        @(negedge clk);
        chk_b("done_clear", done, 1'b0);
        chk_b("divzero_clear", divZero, 1'b0);
        chk_b("busy_idle", busy, 1'b0);
    endtask

    task automatic move(input bit h, input bit l, input logic [31:0] v);
        @(negedge clk);
        mthi = h; mtlo = l; hiLoWriteValue = v;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        if (h) m_hi = v;
        if (l) m_lo = v;
        chk("move_hi", hi, m_hi);
        chk("move_lo", lo, m_lo);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b0; start = 1'b0; op = 2'b00; rsData = 32'h0; rtData = 32'h0;
        mthi = 1'b0; mtlo = 1'b0; hiLoWriteValue = 32'h0;
        #12;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_divzero", divZero, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFD, 32'h5, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h2, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b11, 32'h7, 32'h0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF0, 32'h0, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);

        move(1'b1, 1'b0, 32'h1234);
        move(1'b0, 1'b1, 32'h5678);
        move(1'b1, 1'b1, $urandom);
        run_op(2'b01, 32'h3, 32'h4, 1'b0);
        run_op(2'b00, $urandom, $urandom, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
            run_op(ro, ra, rb, 1'b0);
        end

        // Abort an operation with an asynchronous reset between edges
        run_op(2'b01, 32'h6, 32'h7, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 2'b00; rsData = 32'h6; rtData = 32'h7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_hi", hi, 32'h0);
        chk("async_rst_lo", lo, 32'h0);
        chk_b("async_rst_busy", busy, 1'b0);
        chk_b("async_rst_done", done, 1'b0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        run_op(2'b01, 32'h6, 32'h7, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit owning the HI/LO registers of the mips32 datapath.
- Sits directly downstream of the register file: consumes rsData/rtData for MULT, MULTU, DIV and DIVU.
- Provides HI/LO for MFHI/MFLO and accepts MTHI/MTLO writes.
- Raises busy so the hazard/control logic stalls dependent instructions until the result is committed.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rsData  input  WIDTH  operand A (multiplicand / dividend).
- rtData  input  WIDTH  operand B (multiplier / divisor).
- mthi  input  1  write hiLoWriteValue to HI.
- mtlo  input  1  write hiLoWriteValue to LO.
- hiLoWriteValue  input  WIDTH  data for MTHI/MTLO.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse in the cycle after HI/LO are committed.
- divZero  output  1  one-cycle pulse with done when a DIV/DIVU had rtData==0.

Behaviour:
- Reset: rst low immediately forces IDLE, hi=0, lo=0, busy=0, done=0, divZero=0, counter=0, and clears internal accumulators. This applies in any state, including mid-operation; a partial result is discarded.
- FSM states: IDLE, CALC, FIX.
- IDLE -> CALC on start=1 at a rising edge (edge 0).
  - Operands are latched at edge 0; signed ops (MULT/DIV) take magnitudes and record the result signs.
  - busy=1 from edge 0.
- CALC: one iteration per edge on edges 1..WIDTH.
  - Multiply: shift-add, one multiplier bit per iteration, 2*WIDTH-bit unsigned product.
  - Divide: restoring, one quotient bit per iteration.
  - At edge WIDTH the FSM moves to FIX.
- FIX (edge WIDTH+1, i.e. edge 33 at default):
  - Apply sign correction and write HI/LO.
  - Return to IDLE with busy=0.
  - done=1 (and divZero if applicable) during the following cycle only.
- Total latency: result visible on hi/lo after edge 33; busy high for exactly 33 cycles.
- Sign rules:
  - MULT/MULTU: {HI,LO} = full 64-bit product (two's complement for MULT).
  - DIV: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - DIVU: unsigned.
- Boundary conditions:
  - Divide by zero: normal latency, HI = rsData, LO = all ones, divZero pulses.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0; divZero stays 0.
  - start while busy: ignored, with no effect on the running operation.
  - mthi/mtlo while busy: ignored; control guarantees a stall.
  - mthi/mtlo in IDLE: write on the next edge; both may be asserted together.
  - start together with mthi/mtlo in IDLE: start wins and the move is discarded.
  - op, rsData and rtData may change after edge 0 without affecting the result.
  - hi/lo hold their old values throughout CALC and FIX until the commit edge.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> after edge 33: hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high 33 cycles; done pulse one cycle.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=7, rt=0 -> hi=0x00000007, lo=0xFFFFFFFF, divZero and done pulse together.
- Sequence: mthi=1 with value 0x1234 then mtlo=1 with value 0x5678 in IDLE -> hi=0x1234, lo=0x5678. Then start MULTU 3*4; a second start (DIVU) at cycle 10 is ignored -> hi=0, lo=12 at edge 33.
- Start MULT 6*7, pull rst low at cycle 15 between clock edges -> hi/lo/busy go to 0 immediately. Release rst, start MULTU 6*7 -> lo=42 after 33 cycles.
